// File: rtl/md_pkg.sv
// Shared types for the MD force pipeline.
//   full_id_t        : full particle ID (3*cell + particle)
//   wb_pkt_t         : writeback packet {id, force_z, force_y, force_x}
//   wb_sched_state_t : writeback scheduler phase
//   sat_inc32        : saturating 32-bit increment
package md_pkg;

  localparam int MD_ID_WIDTH   = 16;
  localparam int MD_DATA_WIDTH = 32;

  typedef logic [MD_ID_WIDTH-1:0] full_id_t;

  typedef struct packed {
    full_id_t                 id;
    logic [MD_DATA_WIDTH-1:0] force_z;
    logic [MD_DATA_WIDTH-1:0] force_y;
    logic [MD_DATA_WIDTH-1:0] force_x;
  } wb_pkt_t;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    EVAL_DRAIN = 3'd1,
    START      = 3'd2,
    WB         = 3'd3,
    DONE       = 3'd4
  } wb_sched_state_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/wb_req_fifo.sv
// Per-requester writeback FIFO.
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   push        : push request (accepted only when not full)
//   push_data   : data to push
//   pop         : pop request (caller pops only when count != 0)
//   head        : oldest entry
//   count       : occupancy
//   ready       : registered, high when occupancy <= DEPTH-2
//   drop        : push arrived while full (packet discarded)
module wb_req_fifo #(
  parameter int WIDTH = 112,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       ready,
  output logic                       drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    count_nxt_s;
  logic             ready_r;
  logic             full_s;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Fullness is judged on the occupancy at the start of the cycle, so a push
  // into a full FIFO is dropped even if the same cycle pops.
  always_comb begin
    full_s      = (count_r == CW'(DEPTH));
    push_ok_s   = push && !full_s;
    pop_ok_s    = pop && (count_r != {CW{1'b0}});
    drop        = push && full_s;
    count_nxt_s = count_r + CW'(push_ok_s) - CW'(pop_ok_s);
  end

  // Storage array, no reset needed: entries are only read once written.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers, occupancy and ready; ready is derived from next occupancy so
  // the registered value tracks the current count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      ready_r  <= 1'b0;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      count_r <= count_nxt_s;
      ready_r <= (count_nxt_s <= CW'(DEPTH-2));
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;
  assign ready = ready_r;

endmodule

// File: rtl/force_wb_scheduler.sv
// Writeback scheduler: buffers NUM_REQ force-distributor writeback streams,
// drains them round-robin onto one network port, and sequences the phase.
// Ports:
//   clk, rst_n      : clock, async active-low reset
//   eval_done       : pulse, pair evaluation for the home cell issued
//   req_wb / _valid : per-distributor packets (pushed unconditionally)
//   req_ref_issued  : per-distributor "all ref writebacks issued" pulse
//   req_ready       : per-distributor registered ready
//   start_wb        : one-cycle start pulse to all distributors
//   net_out/_valid  : network packet, valid/ready with net_ready
//   wb_phase_done   : one-cycle pulse at end of the writeback phase
//   busy            : FSM not in IDLE
//   overflow_err    : sticky, a push hit a full FIFO
// Optional build macro FORCE_WB_SCHED_PERF_EN adds perf_stall_cycles and
// perf_pkt_count (saturating, cleared on reset and at each START).
module force_wb_scheduler
  import md_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 16,
  parameter int WB_WIDTH   = ID_WIDTH + 3*DATA_WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        eval_done,
  input  logic [NUM_REQ*WB_WIDTH-1:0] req_wb,
  input  logic [NUM_REQ-1:0]          req_wb_valid,
  input  logic [NUM_REQ-1:0]          req_ref_issued,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_REQ-1:0]          start_wb,
  output logic [WB_WIDTH-1:0]         net_out,
  output logic                        net_valid,
  input  logic                        net_ready,
  output logic                        wb_phase_done,
  output logic                        busy,
  output logic                        overflow_err
`ifdef FORCE_WB_SCHED_PERF_EN
  ,
  output logic [31:0]                 perf_stall_cycles,
  output logic [31:0]                 perf_pkt_count
`endif
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(FIFO_DEPTH+1);

  logic [WB_WIDTH-1:0] head_s  [NUM_REQ];
  logic [CW-1:0]       count_s [NUM_REQ];
  logic [NUM_REQ-1:0]  nonempty_s;
  logic [NUM_REQ-1:0]  pop_s;
  logic [NUM_REQ-1:0]  drop_s;
  logic [NUM_REQ-1:0]  ready_s;
  logic [PW-1:0]       ptr_r;
  logic [PW-1:0]       gnt_idx_s;
  logic                gnt_s;
  logic                load_s;
  logic                all_empty_s;
  logic [WB_WIDTH-1:0] out_r;
  logic                out_valid_r;
  wb_sched_state_t     state_r;
  logic [NUM_REQ-1:0]  done_r;
  logic [NUM_REQ-1:0]  start_wb_r;
  logic                phase_done_r;
  logic                busy_r;
  logic                overflow_r;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_fifo
    wb_req_fifo #(
      .WIDTH(WB_WIDTH),
      .DEPTH(FIFO_DEPTH)
    ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (req_wb_valid[i]),
      .push_data(req_wb[i*WB_WIDTH +: WB_WIDTH]),
      .pop      (pop_s[i]),
      .head     (head_s[i]),
      .count    (count_s[i]),
      .ready    (ready_s[i]),
      .drop     (drop_s[i])
    );
    assign nonempty_s[i] = (count_s[i] != {CW{1'b0}});
  end

  // Round-robin search from ptr+1; descending scan so the nearest candidate
  // after ptr wins. No grant when the output register cannot take a packet.
  always_comb begin
    logic [PW-1:0] cand_v;
    logic          hit_v;
    cand_v      = {PW{1'b0}};
    hit_v       = 1'b0;
    load_s      = !out_valid_r || net_ready;
    all_empty_s = ~|nonempty_s;
    gnt_s       = 1'b0;
    gnt_idx_s   = ptr_r;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand_v    = PW'((int'(ptr_r) + k) % NUM_REQ);
      hit_v     = load_s && nonempty_s[cand_v];
      gnt_idx_s = hit_v ? cand_v : gnt_idx_s;
      gnt_s     = gnt_s | hit_v;
    end
    pop_s = {NUM_REQ{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      pop_s[i] = gnt_s && (gnt_idx_s == PW'(i));
    end
  end

  // Output register and arbiter pointer; holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_r       <= {WB_WIDTH{1'b0}};
      out_valid_r <= 1'b0;
      ptr_r       <= {PW{1'b0}};
    end else if (gnt_s) begin
      out_r       <= head_s[gnt_idx_s];
      out_valid_r <= 1'b1;
      ptr_r       <= gnt_idx_s;
    end else if (load_s) begin
      out_valid_r <= 1'b0;
    end
  end

  // Sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_r <= 1'b0;
    end else if (|drop_s) begin
      overflow_r <= 1'b1;
    end
  end

  // Phase FSM. "Output empty or accepted" (load_s) means the register is
  // empty after this edge, so phase end lands one cycle after the last accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      done_r       <= {NUM_REQ{1'b0}};
      start_wb_r   <= {NUM_REQ{1'b0}};
      phase_done_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (eval_done) begin
            state_r <= EVAL_DRAIN;
            busy_r  <= 1'b1;
          end
        end
        EVAL_DRAIN: begin
          if (all_empty_s && load_s) begin
            state_r    <= START;
            start_wb_r <= {NUM_REQ{1'b1}};
          end
        end
        START: begin
          start_wb_r <= {NUM_REQ{1'b0}};
          done_r     <= req_ref_issued;
          state_r    <= WB;
        end
        WB: begin
          done_r <= done_r | req_ref_issued;
          if ((&done_r) && all_empty_s && load_s) begin
            state_r      <= DONE;
            phase_done_r <= 1'b1;
          end
        end
        DONE: begin
          phase_done_r <= 1'b0;
          busy_r       <= 1'b0;
          state_r      <= IDLE;
        end
        default: begin
          state_r      <= IDLE;
          start_wb_r   <= {NUM_REQ{1'b0}};
          phase_done_r <= 1'b0;
          busy_r       <= 1'b0;
        end
      endcase
    end
  end

`ifdef FORCE_WB_SCHED_PERF_EN
  logic [31:0] stall_r;
  logic [31:0] pkt_r;

  // Performance counters, restarted at every START.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_r <= 32'd0;
      pkt_r   <= 32'd0;
    end else if (state_r == START) begin
      stall_r <= 32'd0;
      pkt_r   <= 32'd0;
    end else begin
      if (out_valid_r && !net_ready) stall_r <= sat_inc32(stall_r);
      if (out_valid_r && net_ready)  pkt_r   <= sat_inc32(pkt_r);
    end
  end

  assign perf_stall_cycles = stall_r;
  assign perf_pkt_count    = pkt_r;
`endif

  assign req_ready     = ready_s;
  assign start_wb      = start_wb_r;
  assign net_out       = out_r;
  assign net_valid     = out_valid_r;
  assign wb_phase_done = phase_done_r;
  assign busy          = busy_r;
  assign overflow_err  = overflow_r;

endmodule

// File: tb/tb_force_wb_scheduler.sv
// Self-checking bench for force_wb_scheduler: queue-based reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_force_wb_scheduler;

  localparam int N  = 4;
  localparam int IW = 16;
  localparam int WW = IW + 3*32;
  localparam int D  = 4;

  typedef logic [WW-1:0] pkt_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            eval_done = 1'b0;
  logic [N*WW-1:0] req_wb = '0;
  logic [N-1:0]    req_wb_valid = '0;
  logic [N-1:0]    req_ref_issued = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    start_wb;
  logic [WW-1:0]   net_out;
  logic            net_valid;
  logic            net_ready = 1'b0;
  logic            wb_phase_done;
  logic            busy;
  logic            overflow_err;
`ifdef FORCE_WB_SCHED_PERF_EN
  logic [31:0]     perf_stall_cycles;
  logic [31:0]     perf_pkt_count;
`endif

  force_wb_scheduler dut (
    .clk(clk), .rst_n(rst_n), .eval_done(eval_done),
    .req_wb(req_wb), .req_wb_valid(req_wb_valid),
    .req_ref_issued(req_ref_issued), .req_ready(req_ready),
    .start_wb(start_wb), .net_out(net_out), .net_valid(net_valid),
    .net_ready(net_ready), .wb_phase_done(wb_phase_done), .busy(busy),
    .overflow_err(overflow_err)
`ifdef FORCE_WB_SCHED_PERF_EN
    , .perf_stall_cycles(perf_stall_cycles), .perf_pkt_count(perf_pkt_count)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int start_cnt = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  pkt_t dut_acc[$];

  // reference model: phase 0 idle, 1 drain, 2 start, 3 writeback, 4 done
  pkt_t       mq[N][$];
  logic       m_valid;
  pkt_t       m_out;
  int         m_ptr;
  int         m_phase;
  logic [N-1:0] m_done;
  logic [N-1:0] m_ready;
  logic       m_ovf;

  task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) mq[i].delete();
    m_valid = 1'b0; m_out = '0; m_ptr = 0; m_phase = 0;
    m_done = '0; m_ready = '0; m_ovf = 1'b0;
  endtask

  task automatic model_step();
    int sz[N];
    int g;
    logic all_empty, can_load;
    all_empty = 1'b1;
    for (int i = 0; i < N; i++) begin
      sz[i] = mq[i].size();
      if (sz[i] != 0) all_empty = 1'b0;
    end
    can_load = !m_valid || net_ready;
    g = -1;
    if (can_load)
      for (int k = 1; k <= N; k++)
        if (g < 0 && sz[(m_ptr + k) % N] > 0) g = (m_ptr + k) % N;
    case (m_phase)
      0: if (eval_done) m_phase = 1;
      1: if (all_empty && can_load) m_phase = 2;
      2: begin m_done = req_ref_issued; m_phase = 3; end
      3: begin
        if (m_done == '1 && all_empty && can_load) m_phase = 4;
        m_done = m_done | req_ref_issued;
      end
      default: m_phase = 0;
    endcase
    if (g >= 0) begin
      m_out = mq[g].pop_front(); m_valid = 1'b1; m_ptr = g;
    end else if (can_load) begin
      m_valid = 1'b0;
    end
    for (int i = 0; i < N; i++)
      if (req_wb_valid[i]) begin
        if (sz[i] == D) m_ovf = 1'b1;
        else mq[i].push_back(req_wb[i*WW +: WW]);
      end
    for (int i = 0; i < N; i++) m_ready[i] = (mq[i].size() <= D-2);
  endtask

  task automatic compare_outputs();
    logic [N-1:0] exp_start;
    exp_start = (m_phase == 2) ? {N{1'b1}} : {N{1'b0}};
    check("net_valid", net_valid, m_valid);
    if (m_valid) check("net_out", net_out, m_out);
    check("req_ready", req_ready, m_ready);
    check("start_wb", start_wb, exp_start);
    check("wb_phase_done", wb_phase_done, m_phase == 4);
    check("busy", busy, m_phase != 0);
    check("overflow_err", overflow_err, m_ovf);
  endtask

  task automatic tick();
    if (net_valid && net_ready) dut_acc.push_back(net_out);
    model_step();
    @(negedge clk);
    cyc++;
    compare_outputs();
    if (start_wb != '0) start_cnt++;
    if (wb_phase_done) begin done_cnt++; done_cyc = cyc; end
    eval_done = 1'b0; req_wb_valid = '0; req_ref_issued = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1 model_reset();
    #1 rst_n = 1'b1;
  endtask

  task automatic set_pkt(input int i, input pkt_t p);
    req_wb[i*WW +: WW] = p;
    req_wb_valid[i] = 1'b1;
  endtask

  function automatic pkt_t mkpkt(input int req, input int n);
    md_pkg::wb_pkt_t p;
    p.id = 16'(req*256 + (n & 255));
    p.force_z = $urandom; p.force_y = $urandom; p.force_x = $urandom;
    return pkt_t'(p);
  endfunction

  function automatic int req_of(input pkt_t p);
    return int'(p[WW-1 -: 8]);
  endfunction

  initial begin
    pkt_t p;
    pkt_t bp[$];
    int rem[N];
    int iss_at[N];
    int acc0, last_acc, last_iss, marker, cnt1, exp_dc;
    logic started, finished;

    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    compare_outputs();

    // single packet on req 2, uncontended: visible two cycles after push
    net_ready = 1'b1;
    p = 112'hABC0_0000_0000_0000_0000_0000_0001;
    set_pkt(2, p);
    tick(); tick();
    check("single_valid", net_valid, 1'b1);
    check("single_data", net_out, p);
    check("single_busy", busy, 1'b0);
    tick(); tick();

    // round robin from pointer 0: 1,2,3,0 repeating
    do_reset();
    dut_acc.delete();
    net_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < N; i++) set_pkt(i, mkpkt(i, n));
      tick();
    end
    repeat (14) tick();
    check("rr_count", dut_acc.size(), 12);
    for (int j = 0; j < 12 && j < dut_acc.size(); j++)
      check("rr_order", req_of(dut_acc[j]), (j + 1) % N);
    check("rr_ovf", overflow_err, 1'b0);

    // backpressure on req 0
    do_reset();
    dut_acc.delete();
    net_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (req_ready[0]) begin
        p = mkpkt(0, c); bp.push_back(p); set_pkt(0, p);
      end
      tick();
      if (c >= 2) begin
        check("bp_valid_hold", net_valid, 1'b1);
        check("bp_data_hold", net_out, bp[0]);
      end
    end
    check("bp_pushes", bp.size(), 4);
    check("bp_ready_low", req_ready[0], 1'b0);
    net_ready = 1'b1;
    repeat (8) tick();
    check("bp_drained", dut_acc.size(), 4);
    for (int j = 0; j < 4 && j < dut_acc.size() && j < bp.size(); j++)
      check("bp_order", dut_acc[j], bp[j]);

    // full phase sequence, 14 packets per distributor
    start_cnt = 0; done_cnt = 0; done_cyc = -1;
    acc0 = dut_acc.size(); last_acc = -1; last_iss = -1;
    started = 1'b0; finished = 1'b0;
    for (int i = 0; i < N; i++) begin rem[i] = 14; iss_at[i] = -1; end
    eval_done = 1'b1;
    tick();
    for (int t = 0; t < 800 && !finished; t++) begin
      net_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (started && rem[i] > 0 && req_ready[i] && $urandom_range(0, 1) == 1) begin
          set_pkt(i, mkpkt(i, 14 - rem[i]));
          rem[i]--;
          if (rem[i] == 0) iss_at[i] = cyc + 1 + 2*i + $urandom_range(0, 2);
        end else if (started && rem[i] == 0 && iss_at[i] == cyc) begin
          req_ref_issued[i] = 1'b1;
          last_iss = cyc;
        end
      end
      if (net_valid && net_ready) last_acc = cyc;
      tick();
      if (start_wb != '0) started = 1'b1;
      if (wb_phase_done) finished = 1'b1;
    end
    net_ready = 1'b1;
    repeat (5) tick();
    check("phase_finished", finished, 1'b1);
    check("phase_start_once", start_cnt, 1);
    check("phase_done_once", done_cnt, 1);
    check("phase_pkts", dut_acc.size() - acc0, 56);
    exp_dc = (last_acc + 1 > last_iss + 2) ? last_acc + 1 : last_iss + 2;
    check("phase_done_cycle", done_cyc, exp_dc);

    // randomized traffic against the model
    for (int t = 0; t < 1500; t++) begin
      net_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 39) == 0) eval_done = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (req_ready[i] && $urandom_range(0, 2) == 0) set_pkt(i, mkpkt(i, t));
        if ($urandom_range(0, 29) == 0) req_ref_issued[i] = 1'b1;
      end
      tick();
    end

    // overflow: output register occupied, then 5 pushes into req 1
    net_ready = 1'b1;
    repeat (25) tick();
    net_ready = 1'b0;
    set_pkt(0, mkpkt(0, 99));
    tick(); tick();
    marker = dut_acc.size();
    for (int k = 0; k < 5; k++) begin set_pkt(1, mkpkt(1, k)); tick(); end
    tick();
    check("ovf_flag", overflow_err, 1'b1);
    net_ready = 1'b1;
    repeat (10) tick();
    cnt1 = 0;
    for (int j = marker; j < dut_acc.size(); j++) if (req_of(dut_acc[j]) == 1) cnt1++;
    check("ovf_emerged", cnt1, 4);
    check("ovf_sticky", overflow_err, 1'b1);

    // return to idle, then abort a writeback phase with reset
    for (int t = 0; t < 50 && busy; t++) begin req_ref_issued = '1; tick(); end
    eval_done = 1'b1;
    tick();
    for (int t = 0; t < 20 && start_wb == '0; t++) tick();
    tick();
    set_pkt(0, mkpkt(0, 1)); set_pkt(3, mkpkt(3, 1));
    net_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    check("rst_net_valid", net_valid, 1'b0);
    check("rst_net_out", net_out, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_start", start_wb, '0);
    check("rst_done", wb_phase_done, 1'b0);
    check("rst_ready", req_ready, '0);
    check("rst_ovf", overflow_err, 1'b0);
    #2 rst_n = 1'b1;
    model_reset();
    net_ready = 1'b1;
    tick();
    check("rst_idle", busy, 1'b0);
    eval_done = 1'b1;
    tick();
    check("rst_fresh_busy", busy, 1'b1);
    done_cnt = 0;
    for (int t = 0; t < 20 && start_wb == '0; t++) tick();
    req_ref_issued = '1;
    for (int t = 0; t < 20 && done_cnt == 0; t++) tick();
    check("rst_fresh_done", done_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
